// File: rtl/risc_spm_processing_unit.sv
// RISC-SPM datapath: register file, PC, IR, address register, ALU operand Y,
// zero flag Z, and the two bus multiplexers. Executes the control word
// issued by the control unit each cycle.
module risc_spm_processing_unit #(
  parameter int unsigned word_size = 8,
  parameter int unsigned op_size   = 4,
  parameter int unsigned Sel1_size = 3,
  parameter int unsigned Sel2_size = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Load_R0,
  input  logic                 Load_R1,
  input  logic                 Load_R2,
  input  logic                 Load_R3,
  input  logic                 Load_PC,
  input  logic                 Inc_PC,
  input  logic [Sel1_size-1:0] Sel_Bus_1_Mux,
  input  logic [Sel2_size-1:0] Sel_Bus_2_Mux,
  input  logic                 Load_IR,
  input  logic                 Load_Add_R,
  input  logic                 Load_Reg_Y,
  input  logic                 Load_Reg_Z,
  input  logic [word_size-1:0] mem_word,
  output logic [word_size-1:0] instruction,
  output logic                 zero,
  output logic [word_size-1:0] address,
  output logic [word_size-1:0] Bus_1
);

  localparam logic [op_size-1:0] OP_NOP = op_size'(0);
  localparam logic [op_size-1:0] OP_ADD = op_size'(1);
  localparam logic [op_size-1:0] OP_SUB = op_size'(2);
  localparam logic [op_size-1:0] OP_AND = op_size'(3);
  localparam logic [op_size-1:0] OP_NOT = op_size'(4);
  localparam logic [op_size-1:0] OP_EQZ = op_size'(9);

  logic [word_size-1:0] r0, r1, r2, r3;
  logic [word_size-1:0] pc, ir, add_r, reg_y;
  logic                 reg_z;
  logic [word_size-1:0] bus_2;
  logic [word_size-1:0] alu_out;
  logic                 alu_zero;
  logic [op_size-1:0]   opcode;

  assign opcode = ir[word_size-1 -: op_size];

  // Bus_1 source select; unused or unknown selects drive zero
  always_comb begin
    Bus_1 = '0;
    case (Sel_Bus_1_Mux)
      Sel1_size'(0): Bus_1 = r0;
      Sel1_size'(1): Bus_1 = r1;
      Sel1_size'(2): Bus_1 = r2;
      Sel1_size'(3): Bus_1 = r3;
      Sel1_size'(4): Bus_1 = pc;
      default:       Bus_1 = '0;
    endcase
  end

  // Bus_2 source select: ALU result, Bus_1, memory read word, or zero
  always_comb begin
    bus_2 = '0;
    case (Sel_Bus_2_Mux)
      Sel2_size'(0): bus_2 = alu_out;
      Sel2_size'(1): bus_2 = Bus_1;
      Sel2_size'(2): bus_2 = mem_word;
      default:       bus_2 = '0;
    endcase
  end

  // ALU: data_1 = Y, data_2 = Bus_1; arithmetic wraps, carry/borrow dropped
  always_comb begin
    alu_out = '0;
    case (opcode)
      OP_NOP:  alu_out = '0;
      OP_ADD:  alu_out = reg_y + Bus_1;
      OP_SUB:  alu_out = Bus_1 - reg_y;
      OP_AND:  alu_out = reg_y & Bus_1;
      OP_NOT:  alu_out = ~Bus_1;
      OP_EQZ:  alu_out = reg_y ^ Bus_1;
      default: alu_out = '0;
    endcase
  end

  assign alu_zero = (alu_out == '0);

  // Datapath state; all loads take the pre-edge Bus_2 value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0    <= '0;
      r1    <= '0;
      r2    <= '0;
      r3    <= '0;
      pc    <= '0;
      ir    <= '0;
      add_r <= '0;
      reg_y <= '0;
      reg_z <= 1'b0;
    end else begin
      if (Load_R0)    r0    <= bus_2;
      if (Load_R1)    r1    <= bus_2;
      if (Load_R2)    r2    <= bus_2;
      if (Load_R3)    r3    <= bus_2;
      if (Load_IR)    ir    <= bus_2;
      if (Load_Add_R) add_r <= bus_2;
      if (Load_Reg_Y) reg_y <= bus_2;
      if (Load_Reg_Z) reg_z <= alu_zero;
      if (Load_PC)     pc <= bus_2;
      else if (Inc_PC) pc <= pc + word_size'(1);
    end
  end

  assign instruction = ir;
  assign zero        = reg_z;
  assign address     = add_r;

endmodule

// File: tb/tb_risc_spm_processing_unit.sv
// Directed bench for the RISC-SPM datapath with an expected-value scoreboard.
module tb_risc_spm_processing_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       Load_R0, Load_R1, Load_R2, Load_R3;
  logic       Load_PC, Inc_PC;
  logic [2:0] Sel_Bus_1_Mux;
  logic [1:0] Sel_Bus_2_Mux;
  logic       Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z;
  logic [7:0] mem_word;
  logic [7:0] instruction;
  logic       zero;
  logic [7:0] address;
  logic [7:0] Bus_1;

  logic [7:0] mem [256];

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Combinational memory read of the current address
  assign mem_word = mem[address];

  risc_spm_processing_unit dut (
    .clk           (clk),
    .rst           (rst),
    .Load_R0       (Load_R0),
    .Load_R1       (Load_R1),
    .Load_R2       (Load_R2),
    .Load_R3       (Load_R3),
    .Load_PC       (Load_PC),
    .Inc_PC        (Inc_PC),
    .Sel_Bus_1_Mux (Sel_Bus_1_Mux),
    .Sel_Bus_2_Mux (Sel_Bus_2_Mux),
    .Load_IR       (Load_IR),
    .Load_Add_R    (Load_Add_R),
    .Load_Reg_Y    (Load_Reg_Y),
    .Load_Reg_Z    (Load_Reg_Z),
    .mem_word      (mem_word),
    .instruction   (instruction),
    .zero          (zero),
    .address       (address),
    .Bus_1         (Bus_1)
  );

  task automatic clr();
    Load_R0 = 0; Load_R1 = 0; Load_R2 = 0; Load_R3 = 0;
    Load_PC = 0; Inc_PC = 0; Load_IR = 0; Load_Add_R = 0;
    Load_Reg_Y = 0; Load_Reg_Z = 0;
    Sel_Bus_1_Mux = 3'd0; Sel_Bus_2_Mux = 2'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  // Present v on Bus_2 through the memory path
  task automatic put(input logic [7:0] v);
    mem[address] = v;
    Sel_Bus_2_Mux = 2'd2;
  endtask

  task automatic expect_v(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic peek(input logic [2:0] sel);
    Sel_Bus_1_Mux = sel;
    #1;
    chk(Bus_1);
  endtask

  task automatic chk_z();
    chk({7'b0, zero});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    clr();
    rst = 1'b0;
    #2;
    expect_v("por_instruction", 8'h00); chk(instruction);
    expect_v("por_zero", 8'h00);        chk_z();
    expect_v("por_address", 8'h00);     chk(address);
    tick();
    rst = 1'b1;

    // Preload nonzero state
    put(8'hA1); Load_R0 = 1; tick();
    put(8'hB2); Load_R1 = 1; tick();
    put(8'hC3); Load_R2 = 1; tick();
    put(8'hD4); Load_R3 = 1; tick();
    put(8'h33); Load_PC = 1; tick();
    Load_Reg_Z = 1; tick();
    put(8'h5C); Load_IR = 1; tick();
    put(8'h7E); Load_Add_R = 1; tick();
    expect_v("pre_instruction", 8'h5C); chk(instruction);
    expect_v("pre_zero", 8'h01);        chk_z();
    expect_v("pre_address", 8'h7E);     chk(address);
    expect_v("pre_pc", 8'h33);          peek(3'd4);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    expect_v("arst_instruction", 8'h00); chk(instruction);
    expect_v("arst_zero", 8'h00);        chk_z();
    expect_v("arst_address", 8'h00);     chk(address);
    for (int s = 0; s < 5; s++) begin
      expect_v($sformatf("arst_bus1_sel%0d", s), 8'h00);
      peek(3'(s));
    end

    // Hold reset across 3 edges with loads requested
    mem[0] = 8'h99;
    for (int k = 0; k < 3; k++) begin
      Sel_Bus_2_Mux = 2'd2; Load_IR = 1; Inc_PC = 1; Load_R0 = 1; Load_Reg_Y = 1;
      tick();
    end
    expect_v("hold_instruction", 8'h00); chk(instruction);
    expect_v("hold_r0", 8'h00);          peek(3'd0);
    expect_v("hold_pc", 8'h00);          peek(3'd4);
    rst = 1'b1;

    // Fetch
    mem[0] = 8'h16;
    Sel_Bus_1_Mux = 3'd4; Sel_Bus_2_Mux = 2'd1; Load_Add_R = 1; tick();
    expect_v("fetch_address", 8'h00); chk(address);
    Sel_Bus_2_Mux = 2'd2; Load_IR = 1; Inc_PC = 1; tick();
    expect_v("fetch_instruction", 8'h16); chk(instruction);
    expect_v("fetch_pc", 8'h01);          peek(3'd4);

    // ADD R1 <- R0 + R1
    put(8'h05); Load_R0 = 1; tick();
    put(8'h03); Load_R1 = 1; tick();
    put(8'h11); Load_IR = 1; tick();
    Sel_Bus_1_Mux = 3'd0; Sel_Bus_2_Mux = 2'd1; Load_Reg_Y = 1; tick();
    Sel_Bus_1_Mux = 3'd1; Sel_Bus_2_Mux = 2'd0; Load_R1 = 1; Load_Reg_Z = 1; tick();
    expect_v("add_r1", 8'h08);   peek(3'd1);
    expect_v("add_zero", 8'h00); chk_z();

    // SUB to zero
    put(8'h21); Load_IR = 1; tick();
    put(8'h01); Load_Reg_Y = 1; tick();
    put(8'h01); Load_R1 = 1; tick();
    Sel_Bus_1_Mux = 3'd1; Sel_Bus_2_Mux = 2'd0; Load_R1 = 1; Load_Reg_Z = 1; tick();
    expect_v("sub_r1", 8'h00);   peek(3'd1);
    expect_v("sub_zero", 8'h01); chk_z();

    // Z holds without Load_Reg_Z; R3 <- 0 - 1
    Sel_Bus_1_Mux = 3'd1; Sel_Bus_2_Mux = 2'd0; Load_R3 = 1; tick();
    expect_v("zhold_zero", 8'h01); chk_z();
    expect_v("zhold_r3", 8'hFF);   peek(3'd3);

    // SUB operand order: 3 - 5
    put(8'h05); Load_Reg_Y = 1; tick();
    put(8'h03); Load_R1 = 1; tick();
    Sel_Bus_1_Mux = 3'd1; Sel_Bus_2_Mux = 2'd0; Load_R1 = 1; Load_Reg_Z = 1; tick();
    expect_v("sub_order_r1", 8'hFE);  peek(3'd1);
    expect_v("sub_order_zero", 8'h00); chk_z();

    // EQZ equal and unequal
    put(8'h92); Load_IR = 1; tick();
    put(8'h5A); Load_Reg_Y = 1; tick();
    put(8'h5A); Load_R2 = 1; tick();
    Sel_Bus_1_Mux = 3'd2; Load_Reg_Z = 1; tick();
    expect_v("eqz_equal_zero", 8'h01); chk_z();
    put(8'h5B); Load_R2 = 1; tick();
    Sel_Bus_1_Mux = 3'd2; Load_Reg_Z = 1; tick();
    expect_v("eqz_diff_zero", 8'h00); chk_z();

    // NOT in a single cycle
    put(8'h42); Load_IR = 1; tick();
    put(8'hF0); Load_R0 = 1; tick();
    Sel_Bus_1_Mux = 3'd0; Sel_Bus_2_Mux = 2'd0; Load_R2 = 1; Load_Reg_Z = 1; tick();
    expect_v("not_r2", 8'h0F);   peek(3'd2);
    expect_v("not_zero", 8'h00); chk_z();

    // AND 0xF0 & 0x0F
    put(8'h32); Load_IR = 1; tick();
    put(8'hF0); Load_Reg_Y = 1; tick();
    Sel_Bus_1_Mux = 3'd2; Sel_Bus_2_Mux = 2'd0; Load_R3 = 1; Load_Reg_Z = 1; tick();
    expect_v("and_r3", 8'h00);   peek(3'd3);
    expect_v("and_zero", 8'h01); chk_z();

    // ADD wraps modulo 256
    put(8'h13); Load_IR = 1; tick();
    put(8'hFF); Load_Reg_Y = 1; tick();
    put(8'h02); Load_R3 = 1; tick();
    Sel_Bus_1_Mux = 3'd3; Sel_Bus_2_Mux = 2'd0; Load_R3 = 1; Load_Reg_Z = 1; tick();
    expect_v("add_wrap_r3", 8'h01);  peek(3'd3);
    expect_v("add_wrap_zero", 8'h00); chk_z();

    // Undefined opcode yields zero
    put(8'h73); Load_IR = 1; tick();
    Sel_Bus_1_Mux = 3'd3; Sel_Bus_2_Mux = 2'd0; Load_R0 = 1; Load_Reg_Z = 1; tick();
    expect_v("undef_r0", 8'h00);   peek(3'd0);
    expect_v("undef_zero", 8'h01); chk_z();

    // PC wrap and Load_PC priority
    put(8'hFF); Load_PC = 1; tick();
    Inc_PC = 1; tick();
    expect_v("pc_wrap", 8'h00); peek(3'd4);
    put(8'h40); Load_PC = 1; Inc_PC = 1; tick();
    expect_v("pc_load_priority", 8'h40); peek(3'd4);
    expect_v("bus1_sel6", 8'h00); peek(3'd6);
    expect_v("bus1_sel7", 8'h00); peek(3'd7);

    // All four registers load together
    put(8'h77); Load_R0 = 1; Load_R1 = 1; Load_R2 = 1; Load_R3 = 1; tick();
    for (int s = 0; s < 4; s++) begin
      expect_v($sformatf("multi_r%0d", s), 8'h77);
      peek(3'(s));
    end

    if (sb.size() != 0) begin
      n_total++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/risc_spm_processing_unit.md
# risc_spm_processing_unit

Datapath half of the RISC-SPM processor: receives the per-cycle control word issued by the control unit and executes it. It holds the register file R0–R3, PC, IR, address register, ALU operand register Y and zero-flag register Z. It drives the memory address and write data, and returns the current instruction word and zero flag to the control unit. Memory is external: this block presents the address and Bus_1 data, and takes the memory read word back combinationally.

## Interface
- word_size, 8, data/address/instruction width
- op_size, 4, opcode field width (IR[word_size-1 -: op_size])
- Sel1_size, 3, Bus_1 mux select width
- Sel2_size, 2, Bus_2 mux select width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- Load_R0, Load_R1, Load_R2, Load_R3  in  1 each  load register Rn from Bus_2
- Load_PC  in  1  load PC from Bus_2
- Inc_PC  in  1  increment PC
- Sel_Bus_1_Mux  in  Sel1_size  Bus_1 source select
- Sel_Bus_2_Mux  in  Sel2_size  Bus_2 source select
- Load_IR, Load_Add_R, Load_Reg_Y  in  1 each  load IR / Add_R / Y from Bus_2
- Load_Reg_Z  in  1  load Z from ALU zero flag
- mem_word  in  word_size  memory read data for address
- instruction  out  word_size  IR contents
- zero  out  1  Z contents
- address  out  word_size  Add_R contents
- Bus_1  out  word_size  Bus_1 value; memory write data

## Operation
- Bus_1 mux (combinational): 0→R0, 1→R1, 2→R2, 3→R3, 4→PC, 5–7→0x00. An out-of-range or X select never propagates X into state.
- Bus_2 mux (combinational): 0→alu_out, 1→Bus_1, 2→mem_word, 3→0x00.
- ALU (combinational), operands data_1 = Y, data_2 = Bus_1, opcode = IR[7:4]:
  - 0 NOP → 0x00
  - 1 ADD → data_1 + data_2
  - 2 SUB → data_2 − data_1
  - 3 AND → data_1 & data_2
  - 4 NOT → ~data_2
  - 9 EQZ → data_1 ^ data_2, so zero=1 iff the operands are equal
  - all other opcodes → 0x00
- ALU arithmetic is modulo 2^word_size. Carry and borrow are discarded.
- alu_zero = (alu_out == 0). Z captures alu_zero only when Load_Reg_Z is asserted. Z is otherwise held.
- Any combination of Load_R0..R3 asserted together: every selected register loads the same Bus_2 value.
- PC priority:
  - Load_PC wins over Inc_PC: PC ← Bus_2 when both are asserted.
  - Inc_PC alone: PC ← PC+1, with 0xFF wrapping to 0x00.
- Registers load from Bus_2 sampled before the edge. A register may be read on Bus_1 and written in the same cycle (read-before-write).
- Outputs: instruction = IR, zero = Z, address = Add_R. All are register outputs, with no combinational path from the inputs.

## Timing
- Asynchronous reset: on rst falling, all of R0–R3, PC, IR, Add_R, Y and Z go to 0 immediately, so instruction=0x00, zero=0, address=0x00.
- While rst=0, Bus_1 = R0 = 0x00 for select 0.
- First clock edge with rst=1 performs normal updates.
- Reset asserted mid-instruction discards all partial state. No pending load completes.
- Load latency: a control bit asserted in cycle n makes its new value visible on outputs after edge n+1.
- Fetch, as seen by this block:
  - cycle A: Sel_Bus_1_Mux=4, Sel_Bus_2_Mux=1, Load_Add_R → address=PC.
  - cycle B: Sel_Bus_2_Mux=2, Load_IR, Inc_PC → IR=mem[address], PC+1.
- Memory read path: mem_word must settle within the same cycle that address is stable. Sampled at the edge.
- Two-cycle ALU op:
  - decode cycle: Y ← src.
  - execute cycle: dest ← alu_out and Z ← alu_zero at the same edge.
- NOT bypasses Y: result is written to dest and Z in the single decode cycle.

## Test plan
- Reset: pre-load registers to nonzero, pull rst low between edges → all outputs 0x00/0 before the next edge. Hold rst low over 3 edges → values stay 0.
- Fetch: PC=0x00, mem[0x00]=0x16 → after cycles A and B, address=0x00, instruction=0x16, PC=0x01.
- ADD with Z clear: R0=0x05 and R1=0x03 via Bus_2=2 loads; IR=0x11; Y←R0; execute with Sel_Bus_1=1, Sel_Bus_2=0, Load_R1, Load_Reg_Z → R1=0x08, zero=0.
- SUB and EQZ:
  - IR=0x21, Y=0x01, R1=0x01 → R1=0x00, zero=1.
  - IR=0x92 with Y=0x5A, R2=0x5A → zero=1.
  - Same with R2=0x5B → zero=0.
- NOT and AND, one cycle each:
  - IR=0x42, R0=0xF0: Sel_Bus_1=0, Sel_Bus_2=0, Load_R2, Load_Reg_Z → R2=0x0F, zero=0.
  - AND 0xF0 & 0x0F → 0x00, zero=1.
- PC boundaries:
  - PC=0xFF, Inc_PC → 0x00.
  - Load_PC with Inc_PC, mem_word=0x40, Sel_Bus_2=2 → PC=0x40, not 0x41.
  - Sel_Bus_1_Mux=6 → Bus_1=0x00.
